// File: rtl/logic_op_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : logic_op_pkg                                           |
// | Description : Shared types, constants and the per-bit reduction      |
// |               helper for the logic operation unit.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package logic_op_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } op_e;

    localparam int BUF_DEPTH  = 2;
    localparam int MAX_NUM_IN = 8;

    // Reduces one bit column (bit b of every operand) under the selected op.
    // Lanes at or above num_in are ignored. NAND inverts the full AND
    // reduction rather than chaining pairwise NANDs.
    function automatic logic reduce_op(
        input op_e                   op,
        input logic [MAX_NUM_IN-1:0] col,
        input int                    num_in
    );
        logic acc_and;
        logic acc_or;
        logic acc_xor;
        logic res;
        acc_and = 1'b1;
        acc_or  = 1'b0;
        acc_xor = 1'b0;
        for (int k = 0; k < MAX_NUM_IN; k++) begin
            if (k < num_in) begin
                acc_and = acc_and & col[k];
                acc_or  = acc_or  | col[k];
                acc_xor = acc_xor ^ col[k];
            end
        end
        case (op)
            OP_AND:  res = acc_and;
            OP_OR:   res = acc_or;
            OP_XOR:  res = acc_xor;
            default: res = ~acc_and;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_op_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : logic_op_if                                            |
// | Description : Input handshake, output handshake and status bundle    |
// |               of the logic operation unit.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface logic_op_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              in_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_y;
    logic [1:0]              out_op;
    logic [CNT_W-1:0]        txn_count;

    // Producer/consumer side (driver and monitor).
    modport master (
        output in_valid, in_data, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op, txn_count
    );

    // Unit side.
    modport slave (
        input  in_valid, in_data, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op, txn_count
    );
endinterface
`default_nettype wire

// File: rtl/logic_op_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : logic_op_buf                                           |
// | Description : Two-entry synchronous FIFO holding {opcode, result}.   |
// |               Entries are cleared on reset so the head reads zero.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module logic_op_buf
    import logic_op_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              push_i,
    input  wire logic              pop_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    output logic      [DATA_W-1:0] rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic      [1:0]        occ_o
);
    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic              head_q;
    logic              head_d;
    logic [1:0]        occ_q;
    logic [1:0]        occ_d;
    logic              tail;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (occ_q == 2'(BUF_DEPTH));
    assign empty_o = (occ_q == 2'd0);
    assign occ_o   = occ_q;
    assign rdata_o = mem_q[head_q];

    // Tail sits occupancy slots past the head in the two-slot ring.
    assign tail    = head_q ^ occ_q[0];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    // Next head and occupancy; push and pop together leave occupancy unchanged.
    always_comb begin
        head_d = head_q ^ pop_ok;
        occ_d  = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // Storage, head pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            occ_q  <= occ_d;
            if (push_ok) begin
                mem_q[tail] <= wdata_i;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/logic_op_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : logic_op_unit                                          |
// | Description : Bitwise AND/OR/XOR/NAND across NUM_IN operands with a  |
// |               valid/ready input and a two-entry output buffer.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module logic_op_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    logic_op_if.slave bus
);
    localparam int ENTRY_W = WIDTH + 2;

    logic [WIDTH-1:0]   red_y;
    logic [ENTRY_W-1:0] buf_rdata;
    logic               buf_full;
    logic               buf_empty;
    logic [1:0]         buf_occ;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   txn_cnt_q;
    logic [CNT_W-1:0]   txn_cnt_d;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [MAX_NUM_IN-1:0] col;

        // Gather bit b of every operand into one column; unused lanes stay 0.
        always_comb begin
            col = '0;
            for (int k = 0; k < NUM_IN; k++) begin
                col[k] = bus.in_data[k*WIDTH + b];
            end
        end

        assign red_y[b] = reduce_op(op_e'(bus.in_op), col, NUM_IN);
    end

    // in_ready comes from registered occupancy only, so a pop while full
    // cannot open the input in the same cycle.
    assign bus.in_ready  = (buf_occ < 2'(BUF_DEPTH));
    assign push          = bus.in_valid & ~buf_full;
    assign bus.out_valid = ~buf_empty;
    assign pop           = ~buf_empty & bus.out_ready;
    assign bus.out_op    = buf_rdata[ENTRY_W-1 -: 2];
    assign bus.out_y     = buf_rdata[WIDTH-1:0];
    assign bus.txn_count = txn_cnt_q;

    logic_op_buf #(
        .DATA_W (ENTRY_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.in_op, red_y}),
        .rdata_o (buf_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .occ_o   (buf_occ)
    );

    // Accepted-transaction count; wraps silently.
    always_comb begin
        txn_cnt_d = txn_cnt_q;
        if (push) begin
            txn_cnt_d = txn_cnt_q + CNT_W'(1);
        end
    end

    // Counter register; an accept during reset is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else begin
            txn_cnt_q <= txn_cnt_d;
        end
    end
endmodule
`default_nettype wire
